// File: rtl/vme_irq_pkg.sv
// Shared types for the VME interrupter: FSM states, IRQ level, latched selection.
package vme_irq_pkg;

  localparam int IRQ_LINES = 7;

  typedef logic [2:0] irq_lvl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ASSERT,
    ST_RESPOND,
    ST_RELEASE
  } irq_state_t;

  typedef struct packed {
    irq_lvl_t   lvl;
    logic [7:0] vec;
  } irq_sel_t;

  // Active-low line pattern for one level; level 0 drives nothing.
  function automatic logic [IRQ_LINES-1:0] lvlToIrqN(irq_lvl_t lvl);
    logic [IRQ_LINES-1:0] lines;
    lines = '1;
    if (lvl != 3'd0) lines[lvl - 3'd1] = 1'b0;
    return lines;
  endfunction

endpackage

// File: rtl/vme_irq_controller_if.sv
// VME IACK / IRQ bus between the slave decoder (master) and the interrupter (slave).
interface vme_irq_controller_if;
  import vme_irq_pkg::*;

  logic                 iack_cycle_i;
  irq_lvl_t             iack_level_i;
  logic                 iackin_n_i;
  logic                 iackout_n_o;
  logic [IRQ_LINES-1:0] VME_IRQ_n_o;
  logic [7:0]           vec_o;
  logic                 vec_valid_o;

  modport master (
    output iack_cycle_i, iack_level_i, iackin_n_i,
    input  iackout_n_o, VME_IRQ_n_o, vec_o, vec_valid_o
  );

  modport slave (
    input  iack_cycle_i, iack_level_i, iackin_n_i,
    output iackout_n_o, VME_IRQ_n_o, vec_o, vec_valid_o
  );

endinterface

// File: rtl/vme_irq_prio_enc.sv
// Combinational priority pick: highest level among pending sources, ties to lowest index.
module vme_irq_prio_enc
  import vme_irq_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_SRC-1:0]   pending,
  input  logic [3*N_SRC-1:0] levels,
  output logic [IDX_W-1:0]   winIdx,
  output irq_lvl_t           winLvl,
  output logic               winValid
);

  // Strict '>' keeps the earlier (lower) index on a tie and skips level 0.
  always_comb begin
    winIdx   = '0;
    winLvl   = '0;
    winValid = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pending[i] && (levels[3*i +: 3] > winLvl)) begin
        winIdx   = IDX_W'(i);
        winLvl   = levels[3*i +: 3];
        winValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vme_irq_controller.sv
// ROAK VME64x interrupter: request edge to IRQ line in 2 cycles, IACK match to vector in 1.
// Define VME_IRQ_TIMEOUT_EN to drop an IRQ left unacknowledged for TIMEOUT_CYCLES cycles.
module vme_irq_controller
  import vme_irq_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SRC-1:0]     irq_req_i,
  input  logic [3*N_SRC-1:0]   irq_level_i,
  input  logic [8*N_SRC-1:0]   irq_vector_i,
  output logic [N_SRC-1:0]     irq_ack_o,
  output logic                 irq_timeout_o,
  vme_irq_controller_if.slave  vmeBus
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  irq_state_t           state, stateNext;
  logic [N_SRC-1:0]     reqQ, pending, pendSet, pendClr;
  logic [IDX_W-1:0]     encIdx, selIdx;
  irq_lvl_t             encLvl, lvlNext;
  logic                 encValid;
  logic [7:0]           encVec;
  irq_sel_t             sel;
  logic                 iackLive, lvlMatch, iackHit, timeoutHit;

  logic [IRQ_LINES-1:0] irqNQ, irqNNext;
  logic                 iackoutNQ, iackoutNNext;
  logic [7:0]           vecQ, vecNext;
  logic                 vecValidQ, vecValidNext;
  logic [N_SRC-1:0]     ackQ, ackNext;
  logic                 timeoutQ, timeoutNext;

  vme_irq_prio_enc #(.N_SRC(N_SRC), .IDX_W(IDX_W)) prioEnc (
    .pending  (pending),
    .levels   (irq_level_i),
    .winIdx   (encIdx),
    .winLvl   (encLvl),
    .winValid (encValid)
  );

  assign encVec   = irq_vector_i[8*int'(encIdx) +: 8];
  assign iackLive = vmeBus.iack_cycle_i & ~vmeBus.iackin_n_i;
  assign lvlMatch = (vmeBus.iack_level_i == sel.lvl);
  // Once this IACK has been passed downstream it is never claimed back.
  assign iackHit  = (state == ST_ASSERT) & iackLive & lvlMatch & iackoutNQ;

`ifdef VME_IRQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] toCnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || state != ST_ASSERT) toCnt <= '0;
    else                             toCnt <= toCnt + 16'd1;
  end

  assign timeoutHit = (state == ST_ASSERT) && (toCnt == TIMEOUT_LAST);
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
  assign timeoutHit       = 1'b0;
`endif

  // Tracks the input through reset too, so a request held across reset is not a new edge.
  always_ff @(posedge clk_i) reqQ <= irq_req_i;

  always_comb begin
    pendSet = '0;
    for (int i = 0; i < N_SRC; i++)
      pendSet[i] = irq_req_i[i] & ~reqQ[i] & (irq_level_i[3*i +: 3] != 3'd0);
  end

  always_comb begin
    pendClr = '0;
    if (state == ST_ARB && !encValid)               pendClr = '1;
    else if (state == ST_ASSERT && (iackHit || timeoutHit)) pendClr[selIdx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE:    if (|pending || |pendSet) stateNext = ST_ARB;
      ST_ARB:     stateNext = encValid ? ST_ASSERT : ST_IDLE;
      ST_ASSERT:  if (iackHit)         stateNext = ST_RESPOND;
                  else if (timeoutHit) stateNext = ST_RELEASE;
      ST_RESPOND: if (!vmeBus.iack_cycle_i) stateNext = ST_RELEASE;
      ST_RELEASE: stateNext = ST_IDLE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the selection is not latched yet while in ARB.
  always_comb begin
    lvlNext      = (state == ST_ARB) ? encLvl : sel.lvl;
    irqNNext     = (stateNext == ST_ASSERT) ? lvlToIrqN(lvlNext) : '1;
    vecValidNext = (stateNext == ST_RESPOND);
    vecNext      = vecValidNext ? sel.vec : 8'h00;
    ackNext      = '0;
    if (iackHit) ackNext[selIdx] = 1'b1;
    timeoutNext  = (state == ST_ASSERT) && (stateNext == ST_RELEASE);
    iackoutNNext = ~(iackLive &
                     (~iackoutNQ |
                      ~(((state == ST_ASSERT) && lvlMatch) || (state == ST_RESPOND))));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending   <= '0;
      selIdx    <= '0;
      sel       <= '0;
      irqNQ     <= '1;
      iackoutNQ <= 1'b1;
      vecQ      <= 8'h00;
      vecValidQ <= 1'b0;
      ackQ      <= '0;
      timeoutQ  <= 1'b0;
    end else begin
      pending   <= (pending & ~pendClr) | pendSet;
      if (state == ST_ARB) begin
        selIdx  <= encIdx;
        sel.lvl <= encLvl;
        sel.vec <= encVec;
      end
      irqNQ     <= irqNNext;
      iackoutNQ <= iackoutNNext;
      vecQ      <= vecNext;
      vecValidQ <= vecValidNext;
      ackQ      <= ackNext;
      timeoutQ  <= timeoutNext;
    end
  end

  assign vmeBus.VME_IRQ_n_o = irqNQ;
  assign vmeBus.iackout_n_o = iackoutNQ;
  assign vmeBus.vec_o       = vecQ;
  assign vmeBus.vec_valid_o = vecValidQ;
  assign irq_ack_o          = ackQ;
  assign irq_timeout_o      = timeoutQ;

endmodule

// File: tb/tb_vme_irq_controller.sv
// Cycle-by-cycle vector bench for vme_irq_controller; each row drives one clock and checks all outputs.
module tb_vme_irq_controller;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       cyc;
    logic [2:0] lvl;
    logic       inN;
    logic [6:0] eIrq;
    logic       eOut;
    logic [7:0] eVec;
    logic       eVld;
    logic [3:0] eAck;
    logic       eTo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] lvls;
  logic [31:0] vecs;
  logic [3:0]  ack;
  logic        to;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  vme_irq_controller_if bus();

  vme_irq_controller #(.N_SRC(4), .TIMEOUT_CYCLES(100)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .irq_req_i     (req),
    .irq_level_i   (lvls),
    .irq_vector_i  (vecs),
    .irq_ack_o     (ack),
    .irq_timeout_o (to),
    .vmeBus        (bus)
  );

  function automatic vec_t V(input logic r, input logic [3:0] q, input logic c,
                             input logic [2:0] l, input logic n, input logic [6:0] ei,
                             input logic eo, input logic [7:0] ev, input logic evl,
                             input logic [3:0] ea, input logic et);
    vec_t v;
    v.rst = r; v.req = q; v.cyc = c; v.lvl = l; v.inN = n;
    v.eIrq = ei; v.eOut = eo; v.eVec = ev; v.eVld = evl; v.eAck = ea; v.eTo = et;
    return v;
  endfunction

  // Quiet cycle: no IACK, only the IRQ lines are of interest.
  function automatic vec_t Q(input logic [3:0] q, input logic [6:0] ei);
    return V(1'b0, q, 1'b0, 3'd0, 1'b1, ei, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0);
  endfunction

  task automatic run(input vec_t v, input string tag);
    logic [21:0] act, exp;
    rst = v.rst; req = v.req;
    bus.iack_cycle_i = v.cyc; bus.iack_level_i = v.lvl; bus.iackin_n_i = v.inN;
    @(posedge clk);
    #1;
    act = {bus.VME_IRQ_n_o, bus.iackout_n_o, bus.vec_o, bus.vec_valid_o, ack, to};
    exp = {v.eIrq, v.eOut, v.eVec, v.eVld, v.eAck, v.eTo};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got irq=%h iackout=%b vec=%h vld=%b ack=%h to=%b, expected irq=%h iackout=%b vec=%h vld=%b ack=%h to=%b",
               tag, bus.VME_IRQ_n_o, bus.iackout_n_o, bus.vec_o, bus.vec_valid_o, ack, to,
               v.eIrq, v.eOut, v.eVec, v.eVld, v.eAck, v.eTo);
    end
  endtask

  task automatic play(input string name);
    foreach (tbl[i]) run(tbl[i], $sformatf("%s row %0d", name, i));
    tbl.delete();
  endtask

  // At most one IRQ line may ever be low.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ($countones(~bus.VME_IRQ_n_o) > 1) begin
        errors++;
        $display("FAIL one-hot irq: got %h, expected at most one low bit", bus.VME_IRQ_n_o);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 4'h0;
    bus.iack_cycle_i = 1'b0; bus.iack_level_i = 3'd0; bus.iackin_n_i = 1'b1;
    lvls = {3'd4, 3'd5, 3'd2, 3'd3};              // src3..src0
    vecs = {8'h33, 8'h22, 8'h11, 8'hA5};

    // Reset, single source, priority pair, daisy-chain pass, IACKIN gating.
    tbl.push_back(V(1, 4'h0, 0, 0, 1, 7'h7F, 1, 8'h00, 0, 4'h0, 0));
    tbl.push_back(Q(4'h0, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7B));
    tbl.push_back(Q(4'h1, 7'h7B));
    tbl.push_back(V(0, 4'h1, 1, 3, 0, 7'h7F, 1, 8'hA5, 1, 4'h1, 0));
    tbl.push_back(V(0, 4'h1, 1, 3, 0, 7'h7F, 1, 8'hA5, 1, 4'h0, 0));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h0, 7'h7F));
    tbl.push_back(Q(4'h6, 7'h7F));
    tbl.push_back(Q(4'h6, 7'h6F));
    tbl.push_back(V(0, 4'h6, 1, 5, 0, 7'h7F, 1, 8'h22, 1, 4'h4, 0));
    tbl.push_back(Q(4'h6, 7'h7F));
    tbl.push_back(Q(4'h6, 7'h7F));
    tbl.push_back(Q(4'h6, 7'h7F));
    tbl.push_back(Q(4'h6, 7'h7D));
    tbl.push_back(V(0, 4'h6, 1, 6, 0, 7'h7D, 0, 8'h00, 0, 4'h0, 0));
    tbl.push_back(V(0, 4'h6, 1, 6, 0, 7'h7D, 0, 8'h00, 0, 4'h0, 0));
    tbl.push_back(V(0, 4'h6, 1, 6, 1, 7'h7D, 1, 8'h00, 0, 4'h0, 0));
    tbl.push_back(Q(4'h6, 7'h7D));
    tbl.push_back(V(0, 4'h6, 1, 2, 0, 7'h7F, 1, 8'h11, 1, 4'h2, 0));
    tbl.push_back(Q(4'h6, 7'h7F));
    tbl.push_back(Q(4'h6, 7'h7F));
    tbl.push_back(Q(4'h8, 7'h7F));
    tbl.push_back(Q(4'h8, 7'h77));
    tbl.push_back(V(0, 4'h8, 1, 6, 0, 7'h77, 0, 8'h00, 0, 4'h0, 0));
    tbl.push_back(V(0, 4'h8, 1, 6, 0, 7'h77, 0, 8'h00, 0, 4'h0, 0));
    tbl.push_back(Q(4'h8, 7'h77));
    tbl.push_back(V(0, 4'h8, 1, 4, 1, 7'h77, 1, 8'h00, 0, 4'h0, 0));
    tbl.push_back(V(0, 4'h8, 1, 4, 0, 7'h7F, 1, 8'h33, 1, 4'h8, 0));
    tbl.push_back(Q(4'h8, 7'h7F));
    tbl.push_back(Q(4'h8, 7'h7F));
    tbl.push_back(V(0, 4'h8, 1, 1, 0, 7'h7F, 0, 8'h00, 0, 4'h0, 0));
    tbl.push_back(Q(4'h8, 7'h7F));
    play("main");

    // Second edge on source 0 while it is being acknowledged.
    tbl.push_back(Q(4'h0, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7B));
    tbl.push_back(V(0, 4'h1, 1, 3, 0, 7'h7F, 1, 8'hA5, 1, 4'h1, 0));
    tbl.push_back(V(0, 4'h0, 1, 3, 0, 7'h7F, 1, 8'hA5, 1, 4'h0, 0));
    tbl.push_back(V(0, 4'h1, 1, 3, 0, 7'h7F, 1, 8'hA5, 1, 4'h0, 0));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7B));
    tbl.push_back(V(0, 4'h1, 1, 3, 0, 7'h7F, 1, 8'hA5, 1, 4'h1, 0));
    tbl.push_back(Q(4'h1, 7'h7F));
    tbl.push_back(Q(4'h1, 7'h7F));
    play("reedge");

    // Reset while asserting; a request held through reset must not re-fire.
    tbl.push_back(Q(4'h0, 7'h7F));
    tbl.push_back(Q(4'h4, 7'h7F));
    tbl.push_back(Q(4'h4, 7'h6F));
    tbl.push_back(V(1, 4'h4, 0, 0, 1, 7'h7F, 1, 8'h00, 0, 4'h0, 0));
    tbl.push_back(Q(4'h4, 7'h7F));
    tbl.push_back(Q(4'h4, 7'h7F));
    tbl.push_back(Q(4'h4, 7'h7F));
    tbl.push_back(Q(4'h0, 7'h7F));
    tbl.push_back(Q(4'h4, 7'h7F));
    tbl.push_back(Q(4'h4, 7'h6F));
    tbl.push_back(V(0, 4'h4, 1, 5, 0, 7'h7F, 1, 8'h22, 1, 4'h4, 0));
    tbl.push_back(Q(4'h4, 7'h7F));
    tbl.push_back(Q(4'h4, 7'h7F));
    play("reset");

    // Level tie goes to the lower index; a level-0 source is ignored.
    lvls = {3'd4, 3'd5, 3'd5, 3'd0};
    tbl.push_back(Q(4'h0, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h6F));
    tbl.push_back(V(0, 4'h7, 1, 5, 0, 7'h7F, 1, 8'h11, 1, 4'h2, 0));
    tbl.push_back(Q(4'h7, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h6F));
    tbl.push_back(V(0, 4'h7, 1, 5, 0, 7'h7F, 1, 8'h22, 1, 4'h4, 0));
    tbl.push_back(Q(4'h7, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h7F));
    tbl.push_back(Q(4'h7, 7'h7F));
    play("tie");
    lvls = {3'd4, 3'd5, 3'd2, 3'd3};

    // Unacknowledged IRQ: dropped after 100 cycles with the feature, held forever without.
    run(Q(4'h0, 7'h7F), "noack idle");
    run(Q(4'h8, 7'h7F), "noack arb");
    run(Q(4'h8, 7'h77), "noack assert");
`ifdef VME_IRQ_TIMEOUT_EN
    for (int i = 1; i < 100; i++) run(Q(4'h8, 7'h77), $sformatf("timeout wait %0d", i));
    run(V(0, 4'h8, 0, 0, 1, 7'h7F, 1, 8'h00, 0, 4'h0, 1), "timeout pulse");
    run(Q(4'h8, 7'h7F), "timeout idle");
    run(V(0, 4'h8, 1, 4, 0, 7'h7F, 0, 8'h00, 0, 4'h0, 0), "timeout iack passed");
    run(Q(4'h8, 7'h7F), "timeout iack end");
    run(Q(4'h8, 7'h7F), "timeout quiet");
`else
    for (int i = 1; i <= 150; i++) run(Q(4'h8, 7'h77), $sformatf("hold wait %0d", i));
    run(V(0, 4'h8, 1, 4, 0, 7'h7F, 1, 8'h33, 1, 4'h8, 0), "hold late iack");
    run(Q(4'h8, 7'h7F), "hold release");
    run(Q(4'h8, 7'h7F), "hold idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
